// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-register bus interface.
// Bus handshake: there is no valid/ready pairing on the bus side. Every access
// completes in the cycle where cs is high, with no wait states. Read data
// appears on dbr on the following edge, and dbr is 0 on every other cycle.
// dbg_state exposes the receiver state:
//   0 = IDLE, 1 = START, 2 = DATA, 3 = STOP, 4 = BREAK.
module uart_rx #(
   parameter int CLK_HZ = 576000,
   parameter int BAUD   = 115200
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] dbr,
   input  logic [7:0] dbw,
   input  logic       addr,
   input  logic       cs,
   input  logic       we,
   input  logic       rx,
   output logic       irq,
   output logic [2:0] dbg_state
);

   localparam int BIT_DIV  = CLK_HZ / BAUD;
   localparam int HALF_DIV = BIT_DIV / 2;
   localparam int CW       = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(HALF_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            rx_m;
   logic            rx_s;
   logic [7:0]      data_reg;
   logic            ready;
   logic            overrun;
   logic            frame_err;

   logic            cnt_last;
   logic            stop_tick;
   logic            byte_ok;
   logic            byte_bad;
   logic            rd_data;
   logic            rd_status;
   logic            wr_status;
   logic            unused_dbw;

   assign cnt_last  = (cnt == CNT_LAST);
   // The stop bit is sampled one full bit after the last data sample.
   assign stop_tick = (state == ST_STOP) && cnt_last;
   assign byte_ok   = stop_tick && rx_s;
   assign byte_bad  = stop_tick && !rx_s;

   assign rd_data   = cs && !we && !addr;
   assign rd_status = cs && !we && addr;
   assign wr_status = cs && we && addr;

   // Only bits 6 and 5 of a STATUS write do anything.
   assign unused_dbw = ^{dbw[7], dbw[4:0]};

   assign irq       = ready;
   assign dbg_state = state;

   // Two-flop synchronizer for the asynchronous serial line. It idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Receive state machine: it finds the start bit, samples at mid-bit and assembles the byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state <= ST_START;
               end
            end
            ST_START: begin
               // Re-check the line at half a bit. A short low pulse is dropped here.
               if (cnt == CNT_MID) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_last) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt_last) begin
                  cnt   <= '0;
                  state <= rx_s ? ST_IDLE : ST_BREAK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               // Wait for the line to go back high before hunting for a new start bit.
               cnt <= '0;
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Bus registers: read mux, DATA load and the status flags. When a flag is set and cleared on the same edge, the set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbr       <= '0;
         data_reg  <= '0;
         ready     <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (rd_data) begin
            dbr <= data_reg;
         end else if (rd_status) begin
            dbr <= {ready, overrun, frame_err, 5'b0};
         end else begin
            dbr <= '0;
         end

         // A DATA read on the same edge frees the slot, so the new byte loads without an overrun.
         if (byte_ok && (!ready || rd_data)) begin
            data_reg <= shreg;
            ready    <= 1'b1;
         end else if (rd_data) begin
            ready <= 1'b0;
         end

         if (byte_ok && ready && !rd_data) begin
            overrun <= 1'b1;
         end else if (wr_status && dbw[6]) begin
            overrun <= 1'b0;
         end

         if (byte_bad) begin
            frame_err <= 1'b1;
         end else if (wr_status && dbw[5]) begin
            frame_err <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 576000, master clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; BIT_DIV = CLK_HZ/BAUD clocks per bit, HALF_DIV = BIT_DIV/2.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 dbr  output 8  data bus read, registered.
REQ-006 dbw  input  8  data bus write.
REQ-007 addr input  1  register select: 0 = DATA, 1 = STATUS.
REQ-008 cs   input  1  chip select.
REQ-009 we   input  1  1 = write, 0 = read (qualified by cs).
REQ-010 rx   input  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-011 irq  output 1  high while STATUS.ready = 1.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer (reset to 1); all decoding uses synchronized rx_s only.
REQ-013 Counter width SHALL be $clog2(BIT_DIV); the counter clears on every state change and counts 0..BIT_DIV-1 within a bit.
REQ-014 State machine SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: rx_s = 0 -> START, counter cleared.
REQ-016 START: at count HALF_DIV-1, rx_s = 0 -> DATA; rx_s = 1 -> IDLE (glitch rejected, no flags changed).
REQ-017 DATA: sample rx_s every BIT_DIV clocks (mid-bit) into a shift register, LSB first; after the 8th sample -> STOP.
REQ-018 STOP: sample rx_s BIT_DIV clocks after the 8th data sample.
REQ-019 Stop = 1, ready = 0: load byte into DATA register, set ready; -> IDLE.
REQ-020 Stop = 1, ready = 1, no DATA read this cycle: discard byte, set overrun; DATA unchanged; -> IDLE.
REQ-021 Stop = 0: discard byte, set frame_err -> BREAK.
REQ-022 BREAK: remain until rx_s = 1, then -> IDLE.
REQ-023 Read of DATA (cs & !we & addr = 0): dbr <= DATA register on next edge; ready cleared on that edge.
REQ-024 Read of STATUS (cs & !we & addr = 1): dbr <= {ready, overrun, frame_err, 5'b0}; no flags changed.
REQ-025 dbr SHALL be 0 on every cycle without a chip read.
REQ-026 Write to STATUS with dbw[6] = 1 clears overrun; dbw[5] = 1 clears frame_err; other bits ignored.
REQ-027 Write to DATA SHALL have no effect.
REQ-028 DATA read and new-byte load on the same edge: new byte loads, ready stays 1, no overrun; dbr returns the old byte.
REQ-029 Flag-clearing write and flag-set event on the same edge: the set wins.
REQ-030 Receive path SHALL run independently of bus activity; bus accesses never stall or reset it.

Reset
REQ-031 On rst: state IDLE, counter 0, synchronizer 1, shift register 0, DATA 0, ready/overrun/frame_err 0, dbr 0, irq 0.
REQ-032 rst asserted mid-frame SHALL abort the frame; after release, reception resumes only on a new falling edge in IDLE.

Verification (CLK_HZ = 576000, BAUD = 115200: BIT_DIV = 5)
REQ-033 Send 0xA5 (start, bits, stop = 1) -> ready = 1, irq = 1 after stop mid-bit; DATA read -> dbr = 0xA5 next cycle, ready = 0, irq = 0.
REQ-034 Send 0x3C, then 0xC3 without reading -> STATUS = 0xC0; DATA read -> 0x3C.
REQ-035 Send 0x55 with stop bit = 0, hold rx low 3 bit times -> STATUS = 0x20, state BREAK until rx high; STATUS write 0x20 -> STATUS = 0x00.
REQ-036 rx low pulse of 1 clock in IDLE -> no byte, STATUS = 0x00; a following valid 0x81 is received correctly.
REQ-037 Assert rst during the 4th data bit of a frame -> all outputs 0, STATUS = 0x00; next frame 0x7E -> received correctly.
REQ-038 DATA read on the same edge that 0x12 completes with ready = 1 (old byte 0x34) -> dbr = 0x34, then DATA = 0x12, ready = 1, overrun = 0.
